// File: rtl/neuron_learn_layer_seq.sv
// Sequential single-layer neuron array with online learning.
// One shared multiply-accumulate per cycle. The forward pass walks neuron j
// (outer) and input i (inner). When learn is set, an update pass follows in
// the same order. It adjusts the weights and accumulates the averaged
// back-propagated targets.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for in_valid; in_ready high
// S_FWD  | forward MAC pass, M*N cycles
// S_UPD  | weight update / back-propagation pass, M*N cycles
// S_DONE | results presented; out_valid rises one cycle after entry
module neuron_learn_layer_seq #(
    parameter int N        = 16,
    parameter int M        = 22,
    parameter int DW       = 8,
    parameter int WW       = 8,
    parameter int LR_SHIFT = 4,
    parameter int W_INIT   = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  learn,
    input  logic [N*DW-1:0]       in,
    input  logic [M*DW-1:0]       expected_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [M*DW-1:0]       out,
    output logic [N*DW-1:0]       expected_in,
    input  logic [$clog2(M)-1:0]  wt_sel,
    input  logic [$clog2(N)-1:0]  wt_idx,
    output logic [WW-1:0]         wt_data
);

    localparam int MW = $clog2(M);
    localparam int NW = $clog2(N);
    localparam int AW = DW + WW + NW + 1;      // forward accumulator
    localparam int SW = DW + MW + 1;           // back-propagation sums
    localparam int EW = DW + 1;                // signed error
    localparam int PW = EW + DW + 1;           // error * activation
    localparam int QW = EW + WW;               // error * weight
    localparam int SH = 2*DW - WW + 1 + LR_SHIFT;

    localparam logic signed [AW-1:0] ACT_MAX  = AW'((1 << DW) - 1);
    localparam logic signed [QW:0]   BACK_MAX = (QW+1)'((1 << DW) - 1);
    localparam logic signed [PW:0]   W_MAX    = (PW+1)'((1 << (WW-1)) - 1);
    localparam logic signed [PW:0]   W_MIN    = (PW+1)'(-(1 << (WW-1)));
    localparam logic signed [WW-1:0] W_RST    = WW'(W_INIT);

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_UPD, S_DONE} state_t;

    state_t state, state_next;

    logic [N*DW-1:0]        in_q;
    logic [M*DW-1:0]        exp_q;
    logic                   learn_q;
    logic [MW-1:0]          j_cnt;
    logic [NW-1:0]          i_cnt;
    logic signed [AW-1:0]   acc;
    logic signed [WW-1:0]   w [M][N];
    logic [SW-1:0]          s_acc [N];

    logic                   last_i, last_j, last_term;
    logic [DW-1:0]          cur_x, cur_t, cur_o;
    logic signed [WW-1:0]   cur_w;
    logic signed [DW:0]     x_s;
    logic signed [DW+WW:0]  f_prod;
    logic signed [AW-1:0]   acc_next, act;
    logic [DW-1:0]          act_clamp;
    logic signed [EW-1:0]   err;
    logic signed [PW-1:0]   d_prod, delta;
    logic signed [PW:0]     w_sum;
    logic signed [WW-1:0]   w_new;
    logic signed [QW-1:0]   b_prod, b_sh;
    logic signed [QW:0]     b_sum;
    logic [DW-1:0]          b_clamp;
    logic [SW-1:0]          s_next;

    // Shared MAC datapath: forward term, weight update and back-propagated term
    always_comb begin
        last_i    = (i_cnt == NW'(N-1));
        last_j    = (j_cnt == MW'(M-1));
        last_term = last_i && last_j;
        cur_x     = in_q[int'(i_cnt)*DW +: DW];
        cur_t     = exp_q[int'(j_cnt)*DW +: DW];
        cur_o     = out[int'(j_cnt)*DW +: DW];
        cur_w     = w[j_cnt][i_cnt];
        x_s       = $signed({1'b0, cur_x});

        f_prod    = (DW+WW+1)'(x_s) * (DW+WW+1)'(cur_w);
        acc_next  = acc + AW'(f_prod);
        act       = acc_next >>> (WW-1);
        if (act[AW-1])
            act_clamp = '0;
        else if (act > ACT_MAX)
            act_clamp = '1;
        else
            act_clamp = act[DW-1:0];

        err    = $signed({1'b0, cur_t}) - $signed({1'b0, cur_o});
        d_prod = PW'(err) * PW'(x_s);
        delta  = d_prod >>> SH;
        w_sum  = (PW+1)'(delta) + (PW+1)'(cur_w);
        if (w_sum > W_MAX)
            w_new = WW'(W_MAX);
        else if (w_sum < W_MIN)
            w_new = WW'(W_MIN);
        else
            w_new = w_sum[WW-1:0];

        // back-propagated target uses the weight before this cycle's write
        b_prod = QW'(err) * QW'(cur_w);
        b_sh   = b_prod >>> (WW-1);
        b_sum  = (QW+1)'(b_sh) + $signed((QW+1)'({1'b0, cur_x}));
        if (b_sum[QW])
            b_clamp = '0;
        else if (b_sum > BACK_MAX)
            b_clamp = '1;
        else
            b_clamp = b_sum[DW-1:0];
        s_next = s_acc[i_cnt] + SW'(b_clamp);
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = S_FWD;
            end
            S_FWD:  if (last_term) state_next = learn_q ? S_UPD : S_DONE;
            S_UPD:  if (last_term) state_next = S_DONE;
            S_DONE: if (out_valid && out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, MAC accumulation, weight writes and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q        <= '0;
            exp_q       <= '0;
            learn_q     <= 1'b0;
            j_cnt       <= '0;
            i_cnt       <= '0;
            acc         <= '0;
            out         <= '0;
            expected_in <= '0;
            out_valid   <= 1'b0;
            for (int i = 0; i < N; i++)
                s_acc[i] <= '0;
            for (int j = 0; j < M; j++)
                for (int i = 0; i < N; i++)
                    w[j][i] <= W_RST;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_q    <= in;
                        exp_q   <= expected_out;
                        learn_q <= learn;
                        j_cnt   <= '0;
                        i_cnt   <= '0;
                        acc     <= '0;
                        for (int i = 0; i < N; i++)
                            s_acc[i] <= '0;
                    end
                end
                S_FWD, S_UPD: begin
                    if (state == S_FWD) begin
                        if (last_i) begin
                            out[int'(j_cnt)*DW +: DW] <= act_clamp;
                            acc <= '0;
                        end else begin
                            acc <= acc_next;
                        end
                    end else begin
                        w[j_cnt][i_cnt] <= w_new;
                        s_acc[i_cnt]    <= s_next;
                    end
                    if (last_i) begin
                        i_cnt <= '0;
                        j_cnt <= last_j ? '0 : j_cnt + MW'(1);
                    end else begin
                        i_cnt <= i_cnt + NW'(1);
                    end
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        for (int i = 0; i < N; i++)
                            expected_in[i*DW +: DW] <= learn_q ? DW'(s_acc[i] / SW'(M)) : '0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational weight read port; out-of-range selects read zero
    always_comb begin
        wt_data = '0;
        if (int'(wt_sel) < M && int'(wt_idx) < N)
            wt_data = w[wt_sel][wt_idx];
    end

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Self-checking bench for neuron_learn_layer_seq (small configuration).
module tb_neuron_learn_layer_seq;

    localparam int N        = 2;
    localparam int M        = 3;
    localparam int DW       = 8;
    localparam int WW       = 8;
    localparam int LR_SHIFT = 4;
    localparam int W_INIT   = 64;
    localparam int MN       = M * N;
    localparam int AMAX     = (1 << DW) - 1;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              learn = 1'b0;
    logic [N*DW-1:0]   in_bus = '0;
    logic [M*DW-1:0]   expected_out = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [M*DW-1:0]   out_bus;
    logic [N*DW-1:0]   expected_in;
    logic [1:0]        wt_sel = '0;
    logic [0:0]        wt_idx = '0;
    logic [WW-1:0]     wt_data;

    int checks = 0;
    int failures = 0;

    int mw [M][N];
    int mout [M];
    int mein [N];

    always #5 clock = ~clock;

    neuron_learn_layer_seq #(
        .N(N), .M(M), .DW(DW), .WW(WW), .LR_SHIFT(LR_SHIFT), .W_INIT(W_INIT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .learn(learn),
        .in(in_bus),
        .expected_out(expected_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out_bus),
        .expected_in(expected_in),
        .wt_sel(wt_sel),
        .wt_idx(wt_idx),
        .wt_data(wt_data)
    );

    // ---------------- reference model ----------------
    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < M; j++)
            for (int i = 0; i < N; i++)
                mw[j][i] = W_INIT;
        for (int j = 0; j < M; j++) mout[j] = 0;
        for (int i = 0; i < N; i++) mein[i] = 0;
    endtask

    task automatic model_txn(input logic [N*DW-1:0] xv, input logic [M*DW-1:0] ev, input logic lrn);
        int x [N];
        int t [M];
        int s [N];
        int acc, e;
        for (int i = 0; i < N; i++) x[i] = int'(xv[i*DW +: DW]);
        for (int j = 0; j < M; j++) t[j] = int'(ev[j*DW +: DW]);
        for (int j = 0; j < M; j++) begin
            acc = 0;
            for (int i = 0; i < N; i++) acc += mw[j][i] * x[i];
            mout[j] = clampi(acc >>> (WW-1), 0, AMAX);
        end
        for (int i = 0; i < N; i++) begin
            mein[i] = 0;
            s[i] = 0;
        end
        if (lrn) begin
            for (int j = 0; j < M; j++) begin
                e = t[j] - mout[j];
                for (int i = 0; i < N; i++) begin
                    s[i] += clampi(x[i] + ((e * mw[j][i]) >>> (WW-1)), 0, AMAX);
                    mw[j][i] = clampi(mw[j][i] + ((e * x[i]) >>> (2*DW-WW+1+LR_SHIFT)),
                                      -(1 << (WW-1)), (1 << (WW-1)) - 1);
                end
            end
            for (int i = 0; i < N; i++) mein[i] = s[i] / M;
        end
    endtask

    function automatic logic [M*DW-1:0] pack_out();
        logic [M*DW-1:0] r;
        for (int j = 0; j < M; j++) r[j*DW +: DW] = DW'(mout[j]);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] pack_ein();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(mein[i]);
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic read_w(input int j, input int i, output int v);
        wt_sel = 2'(j);
        wt_idx = 1'(i);
        #1 v = int'($signed(wt_data));
    endtask

    // Offers one transaction, scrambles the inputs after the handshake edge
    // and counts edges until out_valid rises (bounded).
    task automatic run_txn(input logic [N*DW-1:0] xv, input logic [M*DW-1:0] ev, input logic lrn,
                           output int lat, output logic [M*DW-1:0] o, output logic [N*DW-1:0] ei);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clock);
            #1 guard++;
        end
        in_bus       = xv;
        expected_out = ev;
        learn        = lrn;
        in_valid     = 1'b1;
        @(posedge clock);
        #1;
        in_valid     = 1'b0;
        in_bus       = (N*DW)'($urandom);
        expected_out = (M*DW)'($urandom);
        learn        = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clock);
            #1 lat++;
        end
        o  = out_bus;
        ei = expected_in;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int v;
        do_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if (out_bus !== '0) begin
            failures++; $display("FAIL reset_out got=%h want=0", out_bus);
        end
        for (int j = 0; j < M; j++)
            for (int i = 0; i < N; i++) begin
                read_w(j, i, v);
                checks++;
                if (v !== W_INIT) begin
                    failures++; $display("FAIL reset_weight[%0d][%0d] got=%0d want=%0d", j, i, v, W_INIT);
                end
            end
    endtask

    task automatic test_forward();
        logic [N*DW-1:0] xv = {8'd128, 8'd128};
        logic [M*DW-1:0] o;
        logic [N*DW-1:0] ei;
        int lat;
        model_txn(xv, '0, 1'b0);
        run_txn(xv, '0, 1'b0, lat, o, ei);
        checks++;
        if (lat !== MN + 1) begin
            failures++; $display("FAIL fwd_latency got=%0d want=%0d", lat, MN + 1);
        end
        checks++;
        if (o !== pack_out()) begin
            failures++; $display("FAIL fwd_out got=%h want=%h", o, pack_out());
        end
        checks++;
        if (o !== {3{8'd128}}) begin
            failures++; $display("FAIL fwd_out_abs got=%h want=808080", o);
        end
        checks++;
        if (ei !== '0) begin
            failures++; $display("FAIL fwd_expected_in got=%h want=0", ei);
        end
        release_out();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL fwd_ready_after got=%b want=1", in_ready);
        end
    endtask

    task automatic test_clamp();
        logic [N*DW-1:0] xv = {8'd255, 8'd255};
        logic [M*DW-1:0] o;
        logic [N*DW-1:0] ei;
        int lat;
        do_reset();
        model_txn(xv, '0, 1'b0);
        run_txn(xv, '0, 1'b0, lat, o, ei);
        checks++;
        if (o !== pack_out()) begin
            failures++; $display("FAIL clamp_out got=%h want=%h", o, pack_out());
        end
        checks++;
        if (o !== {3{8'd255}}) begin
            failures++; $display("FAIL clamp_out_abs got=%h want=ffffff", o);
        end
        release_out();
    endtask

    task automatic test_learn();
        logic [N*DW-1:0] xv = {8'd128, 8'd128};
        logic [M*DW-1:0] ev = {3{8'd192}};
        logic [M*DW-1:0] o;
        logic [N*DW-1:0] ei;
        int lat, v;
        model_txn(xv, ev, 1'b1);
        run_txn(xv, ev, 1'b1, lat, o, ei);
        checks++;
        if (lat !== 2*MN + 1) begin
            failures++; $display("FAIL learn_latency got=%0d want=%0d", lat, 2*MN + 1);
        end
        checks++;
        if (o !== pack_out() || o !== {3{8'd128}}) begin
            failures++; $display("FAIL learn_out got=%h want=%h", o, pack_out());
        end
        checks++;
        if (ei !== pack_ein() || ei !== {2{8'd160}}) begin
            failures++; $display("FAIL learn_expected_in got=%h want=%h", ei, pack_ein());
        end
        release_out();
        for (int j = 0; j < M; j++)
            for (int i = 0; i < N; i++) begin
                read_w(j, i, v);
                checks++;
                if (v !== mw[j][i] || v !== 65) begin
                    failures++; $display("FAIL learn_weight[%0d][%0d] got=%0d want=%0d", j, i, v, mw[j][i]);
                end
            end
        model_txn(xv, '0, 1'b0);
        run_txn(xv, '0, 1'b0, lat, o, ei);
        checks++;
        if (o !== pack_out() || o !== {3{8'd130}}) begin
            failures++; $display("FAIL learn_refwd_out got=%h want=%h", o, pack_out());
        end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [N*DW-1:0] xv = (N*DW)'($urandom);
        logic [M*DW-1:0] o;
        logic [N*DW-1:0] ei;
        int lat;
        model_txn(xv, '0, 1'b0);
        run_txn(xv, '0, 1'b0, lat, o, ei);
        checks++;
        if (o !== pack_out()) begin
            failures++; $display("FAIL bp_out got=%h want=%h", o, pack_out());
        end
        in_valid = 1'b1;
        in_bus   = (N*DW)'($urandom);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_bus !== pack_out() || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got valid=%b out=%h ready=%b want valid=1 out=%h ready=0",
                         k, out_valid, out_bus, in_ready, pack_out());
            end
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        end
        @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_no_reaccept got ready=%b want=1", in_ready);
        end
    endtask

    task automatic test_random();
        logic [N*DW-1:0] xv, ei;
        logic [M*DW-1:0] ev, o;
        logic lrn;
        int lat, v;
        for (int n = 0; n < 24; n++) begin
            xv  = (N*DW)'($urandom);
            ev  = (M*DW)'($urandom);
            lrn = (n % 4 != 3) ? 1'($urandom) : 1'b1;
            model_txn(xv, ev, lrn);
            run_txn(xv, ev, lrn, lat, o, ei);
            checks++;
            if (lat !== (lrn ? 2*MN + 1 : MN + 1)) begin
                failures++; $display("FAIL rnd_latency n=%0d got=%0d want=%0d", n, lat, lrn ? 2*MN + 1 : MN + 1);
            end
            checks++;
            if (o !== pack_out()) begin
                failures++; $display("FAIL rnd_out n=%0d got=%h want=%h", n, o, pack_out());
            end
            checks++;
            if (ei !== pack_ein()) begin
                failures++; $display("FAIL rnd_expected_in n=%0d got=%h want=%h", n, ei, pack_ein());
            end
            release_out();
            for (int j = 0; j < M; j++)
                for (int i = 0; i < N; i++) begin
                    read_w(j, i, v);
                    checks++;
                    if (v !== mw[j][i]) begin
                        failures++; $display("FAIL rnd_weight n=%0d [%0d][%0d] got=%0d want=%0d", n, j, i, v, mw[j][i]);
                    end
                end
        end
    endtask

    task automatic test_reset_mid_upd();
        logic [N*DW-1:0] xv = {8'd200, 8'd90};
        logic [M*DW-1:0] ev = {8'd255, 8'd10, 8'd250};
        logic [M*DW-1:0] o;
        logic [N*DW-1:0] ei;
        int lat, v;
        in_bus       = xv;
        expected_out = ev;
        learn        = 1'b1;
        in_valid     = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (MN + 2) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_async got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        model_reset();
        for (int j = 0; j < M; j++)
            for (int i = 0; i < N; i++) begin
                read_w(j, i, v);
                checks++;
                if (v !== W_INIT) begin
                    failures++; $display("FAIL rst_mid_weight[%0d][%0d] got=%0d want=%0d", j, i, v, W_INIT);
                end
            end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bus !== '0) begin
            failures++; $display("FAIL rst_mid_status got valid=%b ready=%b out=%h want 0/1/0", out_valid, in_ready, out_bus);
        end
        xv = {8'd128, 8'd128};
        model_txn(xv, '0, 1'b0);
        run_txn(xv, '0, 1'b0, lat, o, ei);
        checks++;
        if (o !== pack_out() || lat !== MN + 1) begin
            failures++; $display("FAIL rst_mid_refwd got out=%h lat=%0d want out=%h lat=%0d", o, lat, pack_out(), MN + 1);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_clamp();
        test_learn();
        test_backpressure();
        test_random();
        test_reset_mid_upd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
